// File: rtl/icache_pkg.sv
// Shared definitions for the instruction cache: FSM encodings, default
// geometry and boolean constants.
package icache_pkg;

    localparam int IC_INDEX_BITS_DEF       = 6;
    localparam int IC_OFFSET_WORDS_LOG_DEF = 2;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    typedef enum logic {
        ICS_IDLE   = 1'b0,
        ICS_REFILL = 1'b1
    } ics_state_e;

endpackage

// File: rtl/icache_tag_array.sv
// Valid/tag storage for the direct-mapped instruction cache: combinational
// hit compare on the read port, one synchronous write port used by refills.
module icache_tag_array
    import icache_pkg::*;
#(
    parameter int INDEX_BITS = IC_INDEX_BITS_DEF,
    parameter int TAG_BITS   = 22
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [INDEX_BITS-1:0] rd_idx_i,
    input  logic [TAG_BITS-1:0]   rd_tag_i,
    output logic                  hit_o,
    input  logic                  wr_en_i,
    input  logic [INDEX_BITS-1:0] wr_idx_i,
    input  logic [TAG_BITS-1:0]   wr_tag_i
);

    localparam int LINES = 1 << INDEX_BITS;

    logic [LINES-1:0]    valid_q;
    logic [TAG_BITS-1:0] tag_q [LINES];

    // Valid bits: cleared by reset, set when a refill completes.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (rst) begin
            valid_q <= '0;
        end else if (wr_en_i) begin
            valid_q[wr_idx_i] <= TRUE;
        end
    end

    // Tag storage: written alongside the valid bit.
    always_ff @(posedge clk) begin
        // NOTE: storage arrays are deliberately not reset; the valid bits
        // alone decide whether a tag means anything.
        if (wr_en_i) begin
            tag_q[wr_idx_i] <= wr_tag_i;
        end
    end

    assign hit_o = valid_q[rd_idx_i] && (tag_q[rd_idx_i] == rd_tag_i);

endmodule

// File: rtl/icache.sv
// Direct-mapped, read-only instruction cache. Hits answer one cycle after
// acceptance; misses refill the whole line word by word from the memory
// controller and answer straight from the refill path. Mispredict flushes
// suppress stale responses.
module icache
    import icache_pkg::*;
#(
    parameter int INDEX_BITS       = IC_INDEX_BITS_DEF,
    parameter int OFFSET_WORDS_LOG = IC_OFFSET_WORDS_LOG_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        IF_pc_sgn,
    input  logic [31:0] IF_pc,
    output logic        IF_ins_sgn,
    output logic [31:0] IF_ins,
    input  logic        ROB_jp_wrong,
    output logic        MC_req,
    output logic [31:0] MC_addr,
    input  logic        MC_done,
    input  logic [31:0] MC_data
);

    localparam int TAG_BITS = 30 - INDEX_BITS - OFFSET_WORDS_LOG;
    localparam int LINES    = 1 << INDEX_BITS;
    localparam int WORDS    = 1 << OFFSET_WORDS_LOG;
    localparam int IDX_LO   = 2 + OFFSET_WORDS_LOG;
    localparam int TAG_LO   = IDX_LO + INDEX_BITS;
    localparam logic [OFFSET_WORDS_LOG-1:0] LAST_WORD = '1;

    // Address fields of the incoming fetch request.
    logic [OFFSET_WORDS_LOG-1:0] if_off;
    logic [INDEX_BITS-1:0]       if_idx;
    logic [TAG_BITS-1:0]         if_tag;
    logic                        unused_pc_bits;

    assign if_off         = IF_pc[IDX_LO-1:2];
    assign if_idx         = IF_pc[TAG_LO-1:IDX_LO];
    assign if_tag         = IF_pc[31:TAG_LO];
    assign unused_pc_bits = ^IF_pc[1:0];

    ics_state_e                  state_q, state_d;
    logic                        resp_valid_q, resp_valid_d;
    logic [31:0]                 ins_q, ins_d;
    logic                        mc_req_q, mc_req_d;
    logic [31:0]                 mc_addr_q, mc_addr_d;
    logic [OFFSET_WORDS_LOG-1:0] cnt_q, cnt_d;
    logic                        drop_q, drop_d;
    logic [29:0]                 pc_q, pc_d;   // word address of the missed request

    // Fields of the latched miss address.
    logic [OFFSET_WORDS_LOG-1:0] req_off;
    logic [INDEX_BITS-1:0]       req_idx;
    logic [TAG_BITS-1:0]         req_tag;

    assign req_off = pc_q[OFFSET_WORDS_LOG-1:0];
    assign req_idx = pc_q[OFFSET_WORDS_LOG+INDEX_BITS-1:OFFSET_WORDS_LOG];
    assign req_tag = pc_q[29:OFFSET_WORDS_LOG+INDEX_BITS];

    logic        hit;
    logic        tag_we;
    logic        data_we;
    logic [31:0] data_q [LINES][WORDS];

    icache_tag_array #(
        .INDEX_BITS (INDEX_BITS),
        .TAG_BITS   (TAG_BITS)
    ) u_tag_array (
        .clk      (clk),
        .rst      (rst),
        .rd_idx_i (if_idx),
        .rd_tag_i (if_tag),
        .hit_o    (hit),
        .wr_en_i  (tag_we & rdy),
        .wr_idx_i (req_idx),
        .wr_tag_i (req_tag)
    );

    // Data array: each refill word lands in its slot of the missed line.
    always_ff @(posedge clk) begin
        if (rdy && data_we) begin
            data_q[req_idx][cnt_q] <= MC_data;
        end
    end

    // Next-state and output logic for the lookup/refill FSM.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one
        // unassigned, which would otherwise infer a latch.
        state_d      = state_q;
        resp_valid_d = FALSE;
        ins_d        = ins_q;
        mc_req_d     = mc_req_q;
        mc_addr_d    = mc_addr_q;
        cnt_d        = cnt_q;
        drop_d       = drop_q;
        pc_d         = pc_q;
        tag_we       = FALSE;
        data_we      = FALSE;

        case (state_q)
            ICS_IDLE: begin
                drop_d = FALSE;
                if (IF_pc_sgn) begin
                    if (hit) begin
                        resp_valid_d = TRUE;
                        ins_d        = data_q[if_idx][if_off];
                    end else begin
                        pc_d      = IF_pc[31:2];
                        mc_addr_d = {IF_pc[31:IDX_LO], {IDX_LO{1'b0}}};
                        mc_req_d  = TRUE;
                        cnt_d     = '0;
                        state_d   = ICS_REFILL;
                    end
                end
            end
            ICS_REFILL: begin
                // The line still fills on a flush; only the response is dropped.
                if (ROB_jp_wrong) begin
                    drop_d = TRUE;
                end
                if (MC_done) begin
                    data_we   = TRUE;
                    cnt_d     = cnt_q + 1'b1;
                    mc_addr_d = mc_addr_q + 32'd4;
                    if (cnt_q == LAST_WORD) begin
                        tag_we   = TRUE;
                        mc_req_d = FALSE;
                        drop_d   = FALSE;
                        state_d  = ICS_IDLE;
                        if (!drop_q && !ROB_jp_wrong) begin
                            resp_valid_d = TRUE;
                            ins_d = (req_off == cnt_q) ? MC_data
                                                       : data_q[req_idx][req_off];
                        end
                    end
                end
            end
            default: state_d = ICS_IDLE;
        endcase
    end

    // Control registers: reset wins, rdy low freezes everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ICS_IDLE;
            resp_valid_q <= FALSE;
            ins_q        <= '0;
            mc_req_q     <= FALSE;
            mc_addr_q    <= '0;
            cnt_q        <= '0;
            drop_q       <= FALSE;
            pc_q         <= '0;
        end else if (rdy) begin
            state_q      <= state_d;
            resp_valid_q <= resp_valid_d;
            ins_q        <= ins_d;
            mc_req_q     <= mc_req_d;
            mc_addr_q    <= mc_addr_d;
            cnt_q        <= cnt_d;
            drop_q       <= drop_d;
            pc_q         <= pc_d;
        end
    end

    assign IF_ins_sgn = resp_valid_q & ~ROB_jp_wrong;
    assign IF_ins     = ins_q;
    assign MC_req     = mc_req_q;
    assign MC_addr    = mc_addr_q;

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: a table of fetch requests plus directed
// sequences for flushes, rdy stalls and reset. A responder models the memory
// controller; expected refill addresses and responses live in scoreboard queues.
module tb_icache;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic        IF_pc_sgn;
    logic [31:0] IF_pc;
    logic        IF_ins_sgn;
    logic [31:0] IF_ins;
    logic        ROB_jp_wrong;
    logic        MC_req;
    logic [31:0] MC_addr;
    logic        MC_done;
    logic [31:0] MC_data;

    int tests = 0;
    int fails = 0;

    logic [31:0] mc_exp_q [$];
    logic [31:0] resp_q [$];
    int          resp_cnt = 0;
    int          mc_lat   = 0;
    int          mc_wait  = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
        bit          miss;
        int          lat;
    } vec_t;

    vec_t vecs [12];

    icache dut (
        .clk          (clk),
        .rst          (rst),
        .rdy          (rdy),
        .IF_pc_sgn    (IF_pc_sgn),
        .IF_pc        (IF_pc),
        .IF_ins_sgn   (IF_ins_sgn),
        .IF_ins       (IF_ins),
        .ROB_jp_wrong (ROB_jp_wrong),
        .MC_req       (MC_req),
        .MC_addr      (MC_addr),
        .MC_done      (MC_done),
        .MC_data      (MC_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory contents: word at 0x1000 + 4k holds 0xA0 + k.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'hA0 + ((a - 32'h1000) >> 2);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory controller model: answers MC_req after mc_lat idle cycles.
    initial begin
        MC_done = 1'b0;
        MC_data = '0;
        forever begin
            @(negedge clk);
            #1;
            MC_done = 1'b0;
            if (MC_req === 1'b1 && rdy && !rst) begin
                if (mc_wait >= mc_lat) begin
                    mc_wait = 0;
                    MC_done = 1'b1;
                    MC_data = mem_word(MC_addr);
                    if (mc_exp_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL mc_addr_unexpected: got %h expected none", MC_addr);
                    end else begin
                        check("mc_addr", MC_addr, mc_exp_q.pop_front());
                    end
                end else begin
                    mc_wait++;
                end
            end
        end
    end

    // Response monitor: every IF_ins_sgn pulse must match the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (IF_ins_sgn === 1'b1) begin
                resp_cnt++;
                if (resp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL resp_unexpected: got %h expected none", IF_ins);
                end else begin
                    check("resp_ins", IF_ins, resp_q.pop_front());
                end
            end
        end
    end

    // Wait for the next response; lat = cycles waited, -1 on timeout.
    task automatic wait_resp(input int bound, output int lat);
        int start;
        start = resp_cnt;
        lat   = -1;
        for (int i = 1; i <= bound; i++) begin
            @(negedge clk);
            IF_pc_sgn = 1'b0;
            #3;
            if (resp_cnt != start) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic do_req(input logic [31:0] pc, input logic [31:0] exp,
                          input bit miss, input int lat);
        int    got;
        string nm;
        @(negedge clk);
        mc_lat = lat;
        if (miss) begin
            for (int w = 0; w < 4; w++) begin
                mc_exp_q.push_back({pc[31:4], 4'h0} + 32'(4 * w));
            end
        end
        resp_q.push_back(exp);
        IF_pc_sgn = 1'b1;
        IF_pc     = pc;
        wait_resp(60, got);
        nm = miss ? "miss_latency" : "hit_latency";
        check(nm, got, miss ? 4 * (lat + 1) + 1 : 1);
        check("mc_req_after", MC_req, 1'b0);
    endtask

    initial begin
        int start;
        int got;

        vecs[0]  = '{32'h0000_1000, 32'h0A0, 1'b1, 0};
        vecs[1]  = '{32'h0000_1004, 32'h0A1, 1'b0, 0};
        vecs[2]  = '{32'h0000_100C, 32'h0A3, 1'b0, 0};
        vecs[3]  = '{32'h0000_1400, 32'h1A0, 1'b1, 1};
        vecs[4]  = '{32'h0000_140C, 32'h1A3, 1'b0, 0};
        vecs[5]  = '{32'h0000_1000, 32'h0A0, 1'b1, 0};
        vecs[6]  = '{32'h0000_1028, 32'h0AA, 1'b1, 2};
        vecs[7]  = '{32'h0000_103C, 32'h0AF, 1'b1, 0};
        vecs[8]  = '{32'h0000_1016, 32'h0A5, 1'b1, 0};
        vecs[9]  = '{32'h0000_1018, 32'h0A6, 1'b0, 0};
        vecs[10] = '{32'h0000_1000, 32'h0A0, 1'b0, 0};
        vecs[11] = '{32'h0000_102B, 32'h0AA, 1'b0, 0};

        rst          = 1'b1;
        rdy          = 1'b1;
        IF_pc_sgn    = 1'b0;
        IF_pc        = '0;
        ROB_jp_wrong = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ins_sgn", IF_ins_sgn, 1'b0);
        check("rst_ins", IF_ins, 32'h0);
        check("rst_mc_req", MC_req, 1'b0);
        check("rst_mc_addr", MC_addr, 32'h0);
        rst = 1'b0;

        // Table: cold miss, hits, conflict eviction, refill bypass word.
        for (int i = 0; i < 12; i++) begin
            do_req(vecs[i].pc, vecs[i].ins, vecs[i].miss, vecs[i].lat);
        end

        // Back-to-back hits on consecutive cycles.
        @(negedge clk);
        IF_pc_sgn = 1'b1;
        IF_pc     = 32'h1004;
        resp_q.push_back(32'hA1);
        @(negedge clk);
        IF_pc = 32'h100C;
        resp_q.push_back(32'hA3);
        #3;
        check("b2b_sgn0", IF_ins_sgn, 1'b1);
        check("b2b_ins0", IF_ins, 32'hA1);
        check("b2b_mc_req", MC_req, 1'b0);
        @(negedge clk);
        IF_pc_sgn = 1'b0;
        #3;
        check("b2b_sgn1", IF_ins_sgn, 1'b1);
        check("b2b_ins1", IF_ins, 32'hA3);

        // Flush while a hit response is out; redirect hits next cycle.
        @(negedge clk);
        IF_pc_sgn = 1'b1;
        IF_pc     = 32'h1008;
        @(negedge clk);
        ROB_jp_wrong = 1'b1;
        IF_pc        = 32'h1004;
        resp_q.push_back(32'hA1);
        #3;
        check("flush_hit_sgn", IF_ins_sgn, 1'b0);
        @(negedge clk);
        ROB_jp_wrong = 1'b0;
        IF_pc_sgn    = 1'b0;
        #3;
        check("redirect_sgn", IF_ins_sgn, 1'b1);
        check("redirect_ins", IF_ins, 32'hA1);

        // Flush during the 2nd refill word of a miss on 0x2000.
        @(negedge clk);
        mc_lat = 1;
        for (int w = 0; w < 4; w++) mc_exp_q.push_back(32'h2000 + 32'(4 * w));
        start     = resp_cnt;
        IF_pc_sgn = 1'b1;
        IF_pc     = 32'h2000;
        @(negedge clk);
        IF_pc_sgn = 1'b0;
        @(negedge clk);
        @(negedge clk);
        ROB_jp_wrong = 1'b1;
        #3;
        check("flush_refill_addr", MC_addr, 32'h2004);
        @(negedge clk);
        ROB_jp_wrong = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #3;
            if (MC_req === 1'b0) break;
        end
        check("flush_refill_done", MC_req, 1'b0);
        check("flush_refill_words", mc_exp_q.size(), 0);
        repeat (2) @(negedge clk);
        check("flush_refill_no_resp", resp_cnt, start);
        do_req(32'h2008, 32'h4A2, 1'b0, 0);

        // rdy low for 3 cycles in the middle of a refill of 0x1400.
        @(negedge clk);
        mc_lat = 0;
        for (int w = 0; w < 4; w++) mc_exp_q.push_back(32'h1400 + 32'(4 * w));
        resp_q.push_back(32'h1A0);
        IF_pc_sgn = 1'b1;
        IF_pc     = 32'h1400;
        @(negedge clk);
        IF_pc_sgn = 1'b0;
        @(negedge clk);
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #3;
            check("stall_mc_addr", MC_addr, 32'h1404);
            check("stall_mc_req", MC_req, 1'b1);
            check("stall_sgn", IF_ins_sgn, 1'b0);
            @(negedge clk);
        end
        rdy = 1'b1;
        wait_resp(20, got);
        check("stall_resume_latency", got, 3);

        // Reset in the middle of a refill: MC_req drops, all lines miss.
        @(negedge clk);
        for (int w = 0; w < 4; w++) mc_exp_q.push_back(32'h1000 + 32'(4 * w));
        IF_pc_sgn = 1'b1;
        IF_pc     = 32'h1004;
        @(negedge clk);
        IF_pc_sgn = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        mc_exp_q.delete();
        mc_wait = 0;
        #3;
        check("rst_mid_mc_req", MC_req, 1'b0);
        check("rst_mid_sgn", IF_ins_sgn, 1'b0);
        do_req(32'h1014, 32'h0A5, 1'b1, 0);
        do_req(32'h102B, 32'h0AA, 1'b1, 0);
        do_req(32'h1404, 32'h1A1, 1'b1, 0);

        repeat (3) @(negedge clk);
        check("resp_queue_empty", resp_q.size(), 0);
        check("mc_queue_empty", mc_exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got still running expected finished");
        $fatal(1, "timeout");
    end

endmodule
